wb_mem_slave: RTL and testbench

- Wishbone classic slave: the responder end of the bus that the cache's LSU drives as master for line fills, write-backs and uncached accesses.
- Backs a word-addressed, byte-writable on-chip RAM with a programmable number of wait states.
- Decodes a configurable address window; out-of-window accesses are answered with an error.
- Used as the main-memory model under the cache in simulation, and as boot/scratch RAM in the SoC.

---
 rtl/wb_pkg.sv | 14 +
 rtl/wb_mem_array.sv | 29 ++
 rtl/wb_mem_slave.sv | 136 +++++++++++++
 tb/tb_wb_mem_slave.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the memory slave and its RAM array.
package wb_pkg;

    localparam int unsigned WB_DW   = 32;
    localparam int unsigned WB_AW   = 32;
    localparam int unsigned WB_SELW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_mem_array.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
module wb_mem_array
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [WB_SELW-1:0]       we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WB_DW-1:0]         wdata,
    output logic [WB_DW-1:0]         rdata
);

    logic [WB_DW-1:0] mem [DEPTH];

    // Read-first: rdata shows the word as it was before a same-cycle write.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            for (int b = 0; b < WB_SELW; b++) begin
                if (we[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone classic slave backed by byte-writable RAM, with a decoded address window
// and a fixed number of wait states before ack/err.
module wb_mem_slave
    import wb_pkg::*;
#(
    parameter logic [WB_AW-1:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned      SIZE_WORDS = 1024,
    parameter int unsigned      LATENCY    = 2
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic               wb_we_i,
    input  logic [WB_SELW-1:0] wb_sel_i,
    input  logic [WB_AW-1:0]   wb_adr_i,
    input  logic [WB_DW-1:0]   wb_dat_i,
    output logic [WB_DW-1:0]   wb_dat_o,
    output logic               wb_ack_o,
    output logic               wb_err_o
);

    localparam int unsigned      IW         = $clog2(SIZE_WORDS);
    localparam logic [WB_AW-1:0] SIZE_BYTES = WB_AW'(SIZE_WORDS * 4);

    wb_state_e state, state_next;
    logic [3:0] cnt, cnt_next;

    logic [WB_AW-1:0]   offset;
    logic               req;
    logic               in_range;
    logic               accept;
    logic               enter_resp;

    logic [IW-1:0]      cap_idx;
    logic               cap_we;
    logic [WB_SELW-1:0] cap_sel;
    logic [WB_DW-1:0]   cap_dat;
    logic               cap_in_range;

    logic               ram_en;
    logic [WB_SELW-1:0] ram_we;
    logic [IW-1:0]      ram_idx;
    logic [WB_DW-1:0]   ram_wdata;
    logic [WB_DW-1:0]   ram_rdata;
    logic               use_live;

    // Unsigned wrap makes addresses below BASE_ADDR fall out of range.
    assign offset   = wb_adr_i - BASE_ADDR;
    assign in_range = offset < SIZE_BYTES;
    assign req      = wb_cyc_i & wb_stb_i;
    assign accept   = (state == IDLE) & req;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        enter_resp = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                // Expiry wins over a coincident abort: the access still completes.
                if (cnt == 4'd0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end else if (!req) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            cap_idx      <= '0;
            cap_we       <= 1'b0;
            cap_sel      <= '0;
            cap_dat      <= '0;
            cap_in_range <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                cap_idx      <= offset[IW+1:2];
                cap_we       <= wb_we_i;
                cap_sel      <= wb_sel_i;
                cap_dat      <= wb_dat_i;
                cap_in_range <= in_range;
            end
        end
    end

    // With zero wait states the RAM is accessed on the acceptance edge itself.
    assign use_live  = (state == IDLE);
    assign ram_idx   = use_live ? offset[IW+1:2] : cap_idx;
    assign ram_wdata = use_live ? wb_dat_i : cap_dat;
    assign ram_en    = enter_resp & ~rst_i & (use_live ? in_range : cap_in_range);
    assign ram_we    = use_live ? (wb_sel_i & {WB_SELW{wb_we_i}})
                                : (cap_sel & {WB_SELW{cap_we}});

    wb_mem_array #(
        .DEPTH (SIZE_WORDS)
    ) u_mem (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_idx),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign wb_ack_o = (state == RESP) & cap_in_range;
    assign wb_err_o = (state == RESP) & ~cap_in_range;
    assign wb_dat_o = (wb_ack_o & ~cap_we) ? ram_rdata : '0;

endmodule

// File: tb/tb_wb_mem_slave.sv
// Randomized bench for wb_mem_slave against an array model of the memory; three builds
// (LATENCY 2, 0, 15) share one set of bus inputs.
module tb_wb_mem_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;

    logic [31:0] dat_l2, dat_l0, dat_l15;
    logic        ack_l2, ack_l0, ack_l15;
    logic        err_l2, err_l0, err_l15;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] model [1024];

    always #5 clk = ~clk;

    wb_mem_slave #(.BASE_ADDR(32'h0), .SIZE_WORDS(1024), .LATENCY(2)) u_dut (
        .clk(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat),
        .wb_dat_o(dat_l2), .wb_ack_o(ack_l2), .wb_err_o(err_l2)
    );

    wb_mem_slave #(.BASE_ADDR(32'h0), .SIZE_WORDS(1024), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat),
        .wb_dat_o(dat_l0), .wb_ack_o(ack_l0), .wb_err_o(err_l0)
    );

    wb_mem_slave #(.BASE_ADDR(32'h0), .SIZE_WORDS(1024), .LATENCY(15)) u_lat15 (
        .clk(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat),
        .wb_dat_o(dat_l15), .wb_ack_o(ack_l15), .wb_err_o(err_l15)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic ack_of(input int w);
        return (w == 0) ? ack_l2 : (w == 1) ? ack_l0 : ack_l15;
    endfunction

    function automatic logic err_of(input int w);
        return (w == 0) ? err_l2 : (w == 1) ? err_l0 : err_l15;
    endfunction

    function automatic logic [31:0] dat_of(input int w);
        return (w == 0) ? dat_l2 : (w == 1) ? dat_l0 : dat_l15;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // One classic cycle; bus inputs other than cyc/stb/we are scrambled after acceptance.
    task automatic xfer(input int which, input bit w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] d, input bit exp_err, input bit chk_data,
                        input logic [31:0] exp_dat, input int exp_lat, input string tag);
        int  n;
        bit  seen;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                adr  = $urandom;
                wdat = $urandom;
                sel  = 4'($urandom);
            end
            if (ack_of(which) || err_of(which)) seen = 1'b1;
        end
        if (!seen) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            cyc = 1'b0; stb = 1'b0; we = 1'b0;
            return;
        end
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check({tag, "_ack"}, 32'(ack_of(which)), 32'(!exp_err));
        check({tag, "_err"}, 32'(err_of(which)), 32'(exp_err));
        if (exp_err) check({tag, "_errdat"}, dat_of(which), 32'h0);
        else if (chk_data) check({tag, "_dat"}, dat_of(which), exp_dat);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        check({tag, "_width"}, 32'({ack_of(which), err_of(which)}), 32'd0);
    endtask

    task automatic mwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input string tag);
        bit oor;
        oor = (a >= 32'h1000);
        if (!oor) model[a[11:2]] = merge(model[a[11:2]], d, s);
        xfer(0, 1'b1, s, a, d, oor, 1'b0, 32'h0, 3, tag);
    endtask

    task automatic mread(input logic [31:0] a, input string tag);
        bit oor;
        oor = (a >= 32'h1000);
        xfer(0, 1'b0, 4'hF, a, 32'h0, oor, 1'b1, oor ? 32'h0 : model[a[11:2]], 3, tag);
    endtask

    initial begin
        bit          seen;
        logic [31:0] a;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ack", 32'(ack_l2), 32'd0);
        check("rst_err", 32'(err_l2), 32'd0);
        check("rst_dat", dat_l2, 32'h0);

        mwrite(32'h10, 32'hDEAD_BEEF, 4'hF, "wr10");
        mread(32'h10, "rd10");

        mwrite(32'h20, 32'h1122_3344, 4'hF, "wr20");
        mwrite(32'h20, 32'hAABB_CCDD, 4'b0101, "wr20_sel");
        mread(32'h20, "rd20_sel");

        for (int i = 0; i < 8; i++) mwrite(32'h40 + 32'(4 * i), 32'(i * 3), 4'hF, "fill_pre");
        for (int i = 0; i < 8; i++) mread(32'h40 + 32'(4 * i), "fill");

        mwrite(32'h0, 32'h5A5A_0000, 4'hF, "wr0");
        mread(32'h1000, "oor_rd");
        mwrite(32'h1000, 32'hFFFF_FFFF, 4'hF, "oor_wr");
        mread(32'h0, "rd0_after_oor");

        mwrite(32'h10, 32'hFFFF_FFFF, 4'h0, "wr_sel0");
        mread(32'h10, "rd_sel0");

        // Abort: drop strobe one cycle after a write is accepted.
        mwrite(32'h8, 32'h0102_0304, 4'hF, "wr8");
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h8; wdat = 32'hCAFE_F00D;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ack_l2 || err_l2) seen = 1'b1;
        end
        check("abort_noterm", 32'(seen), 32'd0);
        mread(32'h8, "rd8_after_abort");

        // Reset on the cycle whose closing edge would otherwise commit the write.
        mwrite(32'h30, 32'h0BAD_CAFE, 4'hF, "wr30");
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h30; wdat = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ack", 32'(ack_l2), 32'd0);
        check("midrst_err", 32'(err_l2), 32'd0);
        check("midrst_dat", dat_l2, 32'h0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; rst = 1'b0;
        mread(32'h30, "rd30_after_rst");

        for (int i = 0; i < 16; i++) mwrite(32'(4 * i), $urandom, 4'hF, "rnd_pre");
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) a = 32'h1000 + 32'(4 * $urandom_range(0, 100000));
            else a = 32'(4 * $urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) mwrite(a, $urandom, 4'($urandom), "rnd_wr");
            else mread(a, "rnd_rd");
        end

        xfer(1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 1, "lat0_rd");
        xfer(1, 1'b0, 4'hF, 32'h2000, 32'h0, 1'b1, 1'b0, 32'h0, 1, "lat0_oor");
        xfer(2, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 16, "lat15_rd");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
